// File: rtl/alu_seq.sv
// alu_seq: sequential ALU between the B-bus mux and the C-bus write-back.
// Single-cycle ops finish in one clock. SHR and MUL iterate under a
// START/BUSY/DONE handshake. Optional restoring divider on opcode 111 is
// enabled by the macro ALU_DIV_EN; without it, 111 is a NOP.
module alu_seq #(
  parameter int WIDTH = 19,
  parameter int SH_W  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] A_BUS,
  input  logic [WIDTH-1:0] B_BUS,
  input  logic [2:0]       ALU_OP,
  input  logic             START,
  output logic [WIDTH-1:0] C_BUS,
  output logic             Z,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

`ifdef ALU_DIV_EN
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(WIDTH + 1);
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_MUL, S_FIN, S_DIV} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_FIN} state_t;
`endif

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt,   w_cnt_next;
  logic [WIDTH-1:0] r_work,  w_work_next;  // shift value / multiplicand / dividend->quotient
  logic [WIDTH-1:0] r_acc,   w_acc_next;   // product / partial remainder
  logic [WIDTH-1:0] r_opb,   w_opb_next;   // multiplier / divisor
  logic [WIDTH-1:0] r_c,     w_c_next;
  logic             r_z;
  logic             r_done,  w_done_next;
  logic [WIDTH-1:0] w_prod;
  logic [SH_W-1:0]  w_amt;

  assign w_amt  = B_BUS[SH_W-1:0];
  assign w_prod = r_acc + (r_opb[0] ? r_work : '0);

`ifdef ALU_DIV_EN
  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor; the top bit of the difference is the borrow.
  logic [WIDTH:0] w_rem_sh, w_rem_sub;
  assign w_rem_sh  = {r_acc, r_work[WIDTH-1]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_opb};
  assign BUSY = (r_state == S_SHIFT) || (r_state == S_MUL) || (r_state == S_DIV);
`else
  assign BUSY = (r_state == S_SHIFT) || (r_state == S_MUL);
`endif

  assign C_BUS = r_c;
  assign Z     = r_z;
  assign DONE  = r_done;

  // Next-state and datapath decode; results land in C_BUS on the edge that enters FIN.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_work_next  = r_work;
    w_acc_next   = r_acc;
    w_opb_next   = r_opb;
    w_c_next     = r_c;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          case (ALU_OP)
            3'b000: begin w_c_next = B_BUS;          w_done_next = 1'b1; end
            3'b001: begin w_c_next = A_BUS + B_BUS;  w_done_next = 1'b1; end
            3'b010: begin w_c_next = A_BUS - B_BUS;  w_done_next = 1'b1; end
            3'b011: begin w_c_next = A_BUS + 1'b1;   w_done_next = 1'b1; end
            3'b100: begin
              if (w_amt == '0) begin
                w_c_next    = A_BUS;
                w_done_next = 1'b1;
              end else begin
                w_state_next = S_SHIFT;
                w_work_next  = A_BUS;
                // Amounts past the width all yield zero, so cap the dwell.
                w_cnt_next   = (32'(w_amt) >= WIDTH) ? CNT_FULL : CNT_W'(w_amt);
              end
            end
            3'b101: begin
              w_state_next = S_MUL;
              w_cnt_next   = CNT_FULL;
              w_acc_next   = '0;
              w_work_next  = A_BUS;
              w_opb_next   = B_BUS;
            end
            3'b110: begin w_c_next = '0; w_done_next = 1'b1; end
            default: begin
`ifdef ALU_DIV_EN
              if (B_BUS == '0) begin
                w_c_next    = '1;
                w_done_next = 1'b1;
              end else begin
                w_state_next = S_DIV;
                w_cnt_next   = CNT_DIV;
                w_acc_next   = '0;
                w_work_next  = A_BUS;
                w_opb_next   = B_BUS;
              end
`else
              w_done_next = 1'b1;  // NOP: result untouched, still acknowledged
`endif
            end
          endcase
        end
      end
      S_SHIFT: begin
        w_work_next = r_work >> 1;
        w_cnt_next  = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_state_next = S_FIN;
          w_c_next     = r_work >> 1;
          w_done_next  = 1'b1;
        end
      end
      S_MUL: begin
        w_acc_next  = w_prod;
        w_work_next = r_work << 1;
        w_opb_next  = r_opb >> 1;
        w_cnt_next  = r_cnt - CNT_ONE;
        // Leave as soon as no multiplier bits remain.
        if ((r_cnt == CNT_ONE) || ((r_opb >> 1) == '0)) begin
          w_state_next = S_FIN;
          w_c_next     = w_prod;
          w_done_next  = 1'b1;
        end
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        w_cnt_next = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_state_next = S_FIN;
          w_c_next     = r_work;
          w_done_next  = 1'b1;
        end else begin
          w_acc_next  = w_rem_sub[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_rem_sub[WIDTH-1:0];
          w_work_next = {r_work[WIDTH-2:0], ~w_rem_sub[WIDTH]};
        end
      end
`endif
      S_FIN:   w_state_next = S_IDLE;  // START here is deliberately dropped
      default: w_state_next = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
      r_acc   <= '0;
      r_opb   <= '0;
      r_c     <= '0;
      r_z     <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_work  <= w_work_next;
      r_acc   <= w_acc_next;
      r_opb   <= w_opb_next;
      r_c     <= w_c_next;
      r_done  <= w_done_next;
      if (w_done_next) r_z <= (w_c_next == '0);
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed stimulus for alu_seq; a scoreboard
// queue holds expected results and a negedge monitor checks each DONE.
module tb_alu_seq;
  localparam int W = 19;
  localparam longint unsigned WL  = 64'd19;
  localparam longint unsigned MOD = 64'd1 << W;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] A_BUS, B_BUS;
  logic [2:0]   ALU_OP;
  logic         START;
  logic [W-1:0] C_BUS;
  logic         Z, BUSY, DONE;

  alu_seq #(.WIDTH(W), .SH_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .A_BUS(A_BUS), .B_BUS(B_BUS),
    .ALU_OP(ALU_OP), .START(START), .C_BUS(C_BUS), .Z(Z),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  longint unsigned model_c = 0;

  typedef struct {
    longint unsigned c;
    int t0;
    int lmin;
    int lmax;
    int op;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
  endtask

  // Reference behaviour straight from the opcode table.
  function automatic longint unsigned ref_result(input int op, input longint unsigned a,
                                                 input longint unsigned b, input longint unsigned prev);
    longint unsigned amt = b % 64'd32;
    longint unsigned r;
    case (op)
      0: r = b;
      1: r = (a + b) % MOD;
      2: r = (a + MOD - b) % MOD;
      3: r = (a + 64'd1) % MOD;
      4: r = (amt >= WL) ? 64'd0 : (a >> amt);
      5: r = (a * b) % MOD;
      6: r = 64'd0;
`ifdef ALU_DIV_EN
      default: r = (b == 64'd0) ? MOD - 64'd1 : a / b;
`else
      default: r = prev;
`endif
    endcase
    return r;
  endfunction

  // Monitor: pops one expectation per DONE and checks result, flag, timing.
  exp_t mon_e;
  int   mon_lat;
  int   busy_cnt = 0;
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      busy_cnt = 0;
    end else begin
      if (BUSY) busy_cnt++;
      if (DONE) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 64'd1, 64'd0);
        end else begin
          mon_e   = sb.pop_front();
          mon_lat = cyc - mon_e.t0;
          chk("c_bus", 64'(C_BUS), mon_e.c);
          chk("z_flag", 64'(Z), (mon_e.c == 64'd0) ? 64'd1 : 64'd0);
          chk("busy_with_done", 64'(BUSY), 64'd0);
          chk_range("latency", mon_lat, mon_e.lmin, mon_e.lmax);
          chk("busy_cycles", 64'(busy_cnt), 64'(mon_lat));
          $display("op=%0d c=%05h z=%0b lat=%0d busy=%0d", mon_e.op, C_BUS, Z, mon_lat, busy_cnt);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_done();
    int g = 0;
    while (!DONE && g < 60) begin
      @(negedge clk);
      g++;
    end
    if (!DONE) chk("done_timeout", 64'd0, 64'd1);
    @(negedge clk);  // skip the FIN cycle, where START is not accepted
  endtask

  // Issue one op at a negedge with the ALU idle; returns at a negedge with it idle.
  task automatic do_op(input int op, input longint unsigned a, input longint unsigned b);
    exp_t e;
    longint unsigned amt = b % 64'd32;
    A_BUS  = W'(a);
    B_BUS  = W'(b);
    ALU_OP = 3'(op);
    START  = 1'b1;
    e.c  = ref_result(op, a, b, model_c);
    e.t0 = cyc + 1;
    e.op = op;
    e.lmin = 0;
    e.lmax = 0;
    if (op == 4 && amt != 64'd0) begin
      e.lmin = (amt >= WL) ? W : int'(amt);
      e.lmax = e.lmin;
    end
    if (op == 5) begin
      e.lmin = 1;
      e.lmax = W;
    end
`ifdef ALU_DIV_EN
    if (op == 7 && b != 64'd0) begin
      e.lmin = W + 1;
      e.lmax = W + 1;
    end
`endif
    model_c = e.c;
    sb.push_back(e);
    @(negedge clk);
    START  = 1'b0;
    A_BUS  = W'($urandom);
    B_BUS  = W'($urandom);
    ALU_OP = 3'($urandom);
    if (e.lmax != 0) wait_done();
  endtask

  int dir_op[15] = '{1, 2, 2, 3, 0, 6, 4, 4, 4, 5, 5, 5, 7, 7, 7};
  longint unsigned dir_a[15] = '{7, 5, 3, 'h7FFFF, 0, 0, 'h40000, 'h12345, 'h7FFFF,
                                 300, 'h7FFFF, 123, 0, 1000, 5};
  longint unsigned dir_b[15] = '{5, 5, 4, 0, 'h3039, 0, 18, 0, 31,
                                 700, 2, 0, 0, 7, 0};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int g;
    int nb;
    // Reset held with a request pending: nothing may start.
    reset_n = 1'b0;
    START   = 1'b1;
    ALU_OP  = 3'b001;
    A_BUS   = 19'd7;
    B_BUS   = 19'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_c", 64'(C_BUS), 64'd0);
    chk("reset_z", 64'(Z), 64'd1);
    chk("reset_busy", 64'(BUSY), 64'd0);
    chk("reset_done", 64'(DONE), 64'd0);
    reset_n = 1'b1;
    START   = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_done", 64'(DONE), 64'd0);
    chk("idle_c", 64'(C_BUS), 64'd0);

    // Directed table, back-to-back where single-cycle.
    for (int i = 0; i < 15; i++) do_op(dir_op[i], dir_a[i], dir_b[i]);

    // A second START mid-MUL must be ignored.
    A_BUS = 19'd300; B_BUS = 19'd700; ALU_OP = 3'b101; START = 1'b1;
    e.c = 64'd210000; e.t0 = cyc + 1; e.op = 5; e.lmin = 1; e.lmax = W;
    model_c = e.c;
    sb.push_back(e);
    @(negedge clk);
    START = 1'b0;
    @(negedge clk);
    A_BUS = 19'd7; B_BUS = 19'd5; ALU_OP = 3'b001; START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    wait_done();

    // Reset on the 5th BUSY cycle of a MUL discards it.
    A_BUS = 19'd300; B_BUS = 19'd700; ALU_OP = 3'b101; START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    nb = 0;
    g  = 0;
    while (nb < 5 && g < 40) begin
      if (BUSY) nb++;
      if (nb < 5) @(negedge clk);
      g++;
    end
    chk("busy_reached_5", 64'(nb), 64'd5);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midreset_c", 64'(C_BUS), 64'd0);
    chk("midreset_z", 64'(Z), 64'd1);
    chk("midreset_busy", 64'(BUSY), 64'd0);
    chk("midreset_done", 64'(DONE), 64'd0);
    reset_n = 1'b1;
    model_c = 0;
    repeat (25) @(negedge clk);

    // Randomized ops.
    for (int i = 0; i < 150; i++) begin
      longint unsigned ra, rb;
      ra = longint'($urandom) % MOD;
      rb = longint'($urandom) % MOD;
      if ($urandom_range(0, 3) == 0) rb = rb % 64'd32;
      do_op(int'($urandom_range(0, 7)), ra, rb);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
